// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the multi-channel button event debouncer.
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    REL_WAIT
  } btn_state_t;

  function automatic int thr_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counters only ever reach max_thr-1, so clog2(max_thr) bits are enough.
  function automatic int cnt_width(input int max_thr);
    return (max_thr < 2) ? 1 : $clog2(max_thr);
  endfunction

endpackage

// File: rtl/btn_event_channel.sv
// One button: two-flop synchroniser, debounce FSM and event pulse generation.
module btn_event_channel
  import btn_event_pkg::*;
#(
  parameter int PRESS_THR   = 500000,
  parameter int RELEASE_THR = 500000,
  parameter int LONG_THR    = 12500000,
  parameter int REPEAT_THR  = 2500000,
  parameter int CNT_W       = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_THR - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_THR - 1);
  localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_THR - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST  = CNT_W'(REPEAT_THR - 1);

  logic [1:0]       sync_q;
  logic             s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             long_seen;

  assign s = sync_q[1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // Debounce FSM; every output is registered and pulses last one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      long_seen <= 1'b0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == PRESS_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            long_seen <= 1'b0;
            level_o   <= 1'b1;
            press_o   <= 1'b1;
            repeat_o  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state     <= REPEAT;
            cnt       <= '0;
            long_seen <= 1'b1;
            long_o    <= 1'b1;
            repeat_o  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!s) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end else if (cnt == REPEAT_LAST) begin
            cnt      <= '0;
            repeat_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL_WAIT: begin
          if (s) begin
            // A short low glitch returns to the hold phase and restarts its interval.
            state <= long_seen ? REPEAT : HELD;
            cnt   <= '0;
          end else if (cnt == RELEASE_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            level_o   <= 1'b0;
            release_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          level_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_event_debouncer.sv
// Multi-channel button debouncer: one independent event channel per button.
module btn_event_debouncer
  import btn_event_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int PRESS_THR   = 500000,
  parameter int RELEASE_THR = 500000,
  parameter int LONG_THR    = 12500000,
  parameter int REPEAT_THR  = 2500000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  localparam int CNT_W = cnt_width(thr_max(thr_max(PRESS_THR, RELEASE_THR),
                                           thr_max(LONG_THR, REPEAT_THR)));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_event_channel #(
      .PRESS_THR  (PRESS_THR),
      .RELEASE_THR(RELEASE_THR),
      .LONG_THR   (LONG_THR),
      .REPEAT_THR (REPEAT_THR),
      .CNT_W      (CNT_W)
    ) u_channel (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn      (btn[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule

// File: tb/tb_btn_event_debouncer.sv
// Directed self-checking bench for btn_event_debouncer with small thresholds.
module tb_btn_event_debouncer;

  logic       clk;
  logic       reset_n;
  logic [1:0] btn;
  logic [1:0] level_o;
  logic [1:0] press_o;
  logic [1:0] release_o;
  logic [1:0] long_o;
  logic [1:0] repeat_o;

  int test_count = 0;
  int fail_count = 0;
  int edge_num   = 0;

  btn_event_debouncer #(
    .N_CH       (2),
    .PRESS_THR  (4),
    .RELEASE_THR(4),
    .LONG_THR   (10),
    .REPEAT_THR (3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn      (btn),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o),
    .repeat_o (repeat_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] exp_vec(input logic [1:0] lvl, input logic [1:0] pr,
                                         input logic [1:0] rl, input logic [1:0] lg,
                                         input logic [1:0] rp);
    return {lvl, pr, rl, lg, rp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_num++;
  endtask

  task automatic applyStimulus(input logic [1:0] value);
    btn = value;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expected);
    logic [9:0] observed;
    observed = {level_o, press_o, release_o, long_o, repeat_o};
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%b expected=%b (level,press,release,long,repeat)",
             tag, observed, expected);
    end
  endtask

  // Directed sequence; edge_num counts rising edges, edge 1 being the first sample of btn.
  initial begin
    reset_n = 1'b0;
    applyStimulus(2'b00);
    repeat (3) tick();
    checkOutput("reset_held", '0);
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("after_reset", '0);

    // Channel 0 press, long and auto-repeat.
    applyStimulus(2'b01);
    edge_num = 0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      checkOutput($sformatf("t1_e%0d", e),
                  exp_vec({1'b0, e >= 6}, {1'b0, e == 6}, 2'b00, {1'b0, e == 16},
                          {1'b0, (e == 6) || (e == 16) || (e == 19) || (e == 22) || (e == 25)}));
    end

    // Short low glitch while repeating: no release, repeat resumes, no second long.
    applyStimulus(2'b00);
    for (int e = 26; e <= 33; e++) begin
      if (e == 28) applyStimulus(2'b01);
      tick();
      checkOutput($sformatf("t3_e%0d", e),
                  exp_vec(2'b01, 2'b00, 2'b00, 2'b00, {1'b0, e == 33}));
    end

    // Real release: first sampled low at edge 34, release at edge 40.
    applyStimulus(2'b00);
    for (int e = 34; e <= 43; e++) begin
      tick();
      checkOutput($sformatf("t4_e%0d", e),
                  exp_vec({1'b0, e <= 39}, 2'b00, {1'b0, e == 40}, 2'b00, 2'b00));
    end

    // Channel 1 bounces shorter than the press threshold.
    for (int r = 0; r < 5; r++) begin
      applyStimulus(2'b10);
      for (int k = 0; k < 3; k++) begin
        tick();
        checkOutput($sformatf("t2_r%0d_hi%0d", r, k), '0);
      end
      applyStimulus(2'b00);
      for (int k = 0; k < 3; k++) begin
        tick();
        checkOutput($sformatf("t2_r%0d_lo%0d", r, k), '0);
      end
    end
    repeat (3) tick();
    checkOutput("t2_settled", '0);

    // Both channels pressed on the same edge.
    applyStimulus(2'b11);
    edge_num = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checkOutput($sformatf("t5_e%0d", e),
                  exp_vec({2{e >= 6}}, {2{e == 6}}, 2'b00, 2'b00, {2{e == 6}}));
    end

    // Reset while both channels are held: outputs clear at once, no release.
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_clear", '0);
    tick();
    tick();
    checkOutput("t6_in_reset", '0);
    reset_n = 1'b1;
    edge_num = 0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checkOutput($sformatf("t6_e%0d", e),
                  exp_vec({2{e >= 6}}, {2{e == 6}}, 2'b00, 2'b00, {2{e == 6}}));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
